// File: rtl/glip_pattern_pkg.sv
// Shared types for the GLIP FIFO pattern tester: generator and checker FSM states.
package glip_pattern_pkg;

    typedef enum logic {
        GEN_IDLE = 1'b0,
        GEN_RUN  = 1'b1
    } gen_state_t;

    typedef enum logic {
        CHK_UNSYNC = 1'b0,
        CHK_LOCKED = 1'b1
    } chk_state_t;

endpackage

// File: rtl/glip_pattern_checker.sv
// Host->logic sequence checker: locks onto the first word, then counts
// accepted words and (saturating) sequence errors, resyncing on each error.
module glip_pattern_checker #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 32,
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 chk_clear,
    input  logic [WIDTH-1:0]     fifo_in_data,
    input  logic                 fifo_in_valid,
    output logic                 fifo_in_ready,
    output logic                 chk_locked,
    output logic [CNT_WIDTH-1:0] chk_words,
    output logic [ERR_WIDTH-1:0] chk_errors
);
    import glip_pattern_pkg::*;

    // Error counter sticks at all-ones instead of wrapping.
    function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
        return (&v) ? v : v + ERR_WIDTH'(1);
    endfunction

    chk_state_t           state_r, state_nxt_s;
    logic                 ready_r;
    logic                 locked_r, locked_nxt_s;
    logic [WIDTH-1:0]     expected_r, expected_nxt_s;
    logic [CNT_WIDTH-1:0] words_r, words_nxt_s;
    logic [ERR_WIDTH-1:0] errors_r, errors_nxt_s;
    logic                 accept_s;
    logic                 mismatch_s;

    assign accept_s   = fifo_in_valid & ready_r;
    assign mismatch_s = accept_s & (state_r == CHK_LOCKED) & (fifo_in_data != expected_r);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= CHK_UNSYNC;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state: clear wins over an accepted word; any accepted word locks.
    always_comb begin
        state_nxt_s = state_r;
        if (chk_clear) begin
            state_nxt_s = CHK_UNSYNC;
        end else if (accept_s) begin
            state_nxt_s = CHK_LOCKED;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Next values of counters, expected word and lock flag.
    always_comb begin
        words_nxt_s    = words_r;
        errors_nxt_s   = errors_r;
        expected_nxt_s = expected_r;
        locked_nxt_s   = (state_nxt_s == CHK_LOCKED);
        if (chk_clear) begin
            words_nxt_s  = {CNT_WIDTH{1'b0}};
            errors_nxt_s = {ERR_WIDTH{1'b0}};
        end else if (accept_s) begin
            words_nxt_s    = words_r + CNT_WIDTH'(1);
            expected_nxt_s = fifo_in_data + WIDTH'(1);
            if (mismatch_s) begin
                errors_nxt_s = sat_inc(errors_r);
            end else begin
                errors_nxt_s = errors_r;
            end
        end else begin
            words_nxt_s = words_r;
        end
    end

    // Output and datapath registers; ready rises on the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r    <= 1'b0;
            locked_r   <= 1'b0;
            expected_r <= {WIDTH{1'b0}};
            words_r    <= {CNT_WIDTH{1'b0}};
            errors_r   <= {ERR_WIDTH{1'b0}};
        end else begin
            ready_r    <= 1'b1;
            locked_r   <= locked_nxt_s;
            expected_r <= expected_nxt_s;
            words_r    <= words_nxt_s;
            errors_r   <= errors_nxt_s;
        end
    end

    assign fifo_in_ready = ready_r;
    assign chk_locked    = locked_r;
    assign chk_words     = words_r;
    assign chk_errors    = errors_r;

endmodule

// File: rtl/glip_pattern_tester.sv
// Synthetic GLIP FIFO endpoint: incrementing-word generator towards the host
// and an incrementing-sequence checker on the host->logic stream.
module glip_pattern_tester #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 32,
    parameter int ERR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 gen_enable,
    input  logic                 chk_clear,
    output logic [WIDTH-1:0]     fifo_out_data,
    output logic                 fifo_out_valid,
    input  logic                 fifo_out_ready,
    input  logic [WIDTH-1:0]     fifo_in_data,
    input  logic                 fifo_in_valid,
    output logic                 fifo_in_ready,
    output logic                 chk_locked,
    output logic [CNT_WIDTH-1:0] chk_words,
    output logic [ERR_WIDTH-1:0] chk_errors
);
    import glip_pattern_pkg::*;

    gen_state_t       gen_state_r, gen_state_nxt_s;
    logic [WIDTH-1:0] gen_cnt_r, gen_cnt_nxt_s;
    logic             valid_r, valid_nxt_s;
    logic             handshake_s;

    assign handshake_s = valid_r & fifo_out_ready;

    // Generator state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_state_r <= GEN_IDLE;
        end else begin
            gen_state_r <= gen_state_nxt_s;
        end
    end

    // Generator next state: leave RUN only once the pending word is taken.
    always_comb begin
        gen_state_nxt_s = gen_state_r;
        case (gen_state_r)
            GEN_IDLE: begin
                if (gen_enable) begin
                    gen_state_nxt_s = GEN_RUN;
                end else begin
                    gen_state_nxt_s = GEN_IDLE;
                end
            end
            GEN_RUN: begin
                if (handshake_s && !gen_enable) begin
                    gen_state_nxt_s = GEN_IDLE;
                end else begin
                    gen_state_nxt_s = GEN_RUN;
                end
            end
            default: gen_state_nxt_s = GEN_IDLE;
        endcase
    end

    // Generator outputs: valid follows RUN, counter advances per handshake.
    always_comb begin
        valid_nxt_s   = (gen_state_nxt_s == GEN_RUN);
        gen_cnt_nxt_s = gen_cnt_r;
        if (handshake_s) begin
            gen_cnt_nxt_s = gen_cnt_r + WIDTH'(1);
        end else begin
            gen_cnt_nxt_s = gen_cnt_r;
        end
    end

    // Generator output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            gen_cnt_r <= {WIDTH{1'b0}};
        end else begin
            valid_r   <= valid_nxt_s;
            gen_cnt_r <= gen_cnt_nxt_s;
        end
    end

    assign fifo_out_valid = valid_r;
    assign fifo_out_data  = gen_cnt_r;

    glip_pattern_checker #(
        .WIDTH    (WIDTH),
        .CNT_WIDTH(CNT_WIDTH),
        .ERR_WIDTH(ERR_WIDTH)
    ) u_checker (
        .clk          (clk),
        .rst_n        (rst_n),
        .chk_clear    (chk_clear),
        .fifo_in_data (fifo_in_data),
        .fifo_in_valid(fifo_in_valid),
        .fifo_in_ready(fifo_in_ready),
        .chk_locked   (chk_locked),
        .chk_words    (chk_words),
        .chk_errors   (chk_errors)
    );

endmodule
